xadac_mux_rr: RTL and testbench

- Parametrised successor XADAC demultiplexer: one slave-side XADAC port fans out to NoMst coprocessor master ports.
- Decode requests are routed by instruction mask/match; execute requests follow a per-id scoreboard written at decode.
- Decode and execute responses are merged by independent round-robin arbiters with grant lock.
- Sits between the CVA6 XADAC adapter and the set of custom accelerator units.

---
 rtl/xadac_mux_rr_if.sv | 43 ++++
 rtl/xadac_mux_rr.sv | 257 +++++++++++++++++++++++++
 tb/tb_xadac_mux_rr.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadac_mux_rr_if.sv
// ============================================================================
// Module   : xadac_mux_rr_if
// Brief    : XADAC decode/execute channel bundle, N ports wide.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xadac_mux_rr_if #(
    parameter int N       = 1,
    parameter int ID_W    = 4,
    parameter int DATA_W  = 32,
    parameter int INSTR_W = 32
);
    // Request payloads pack the id in the low bits: {instr, id} / {operand, id}
    logic [N-1:0][INSTR_W+ID_W-1:0] dec_req;
    logic [N-1:0]                   dec_req_valid;
    logic [N-1:0]                   dec_req_ready;
    logic [N-1:0][DATA_W-1:0]       dec_rsp;
    logic [N-1:0]                   dec_rsp_valid;
    logic [N-1:0]                   dec_rsp_ready;
    logic [N-1:0][DATA_W+ID_W-1:0]  exe_req;
    logic [N-1:0]                   exe_req_valid;
    logic [N-1:0]                   exe_req_ready;
    logic [N-1:0][DATA_W-1:0]       exe_rsp;
    logic [N-1:0]                   exe_rsp_valid;
    logic [N-1:0]                   exe_rsp_ready;

    modport master (
        output dec_req, dec_req_valid, input  dec_req_ready,
        input  dec_rsp, dec_rsp_valid, output dec_rsp_ready,
        output exe_req, exe_req_valid, input  exe_req_ready,
        input  exe_rsp, exe_rsp_valid, output exe_rsp_ready
    );

    modport slave (
        input  dec_req, dec_req_valid, output dec_req_ready,
        output dec_rsp, dec_rsp_valid, input  dec_rsp_ready,
        input  exe_req, exe_req_valid, output exe_req_ready,
        output exe_rsp, exe_rsp_valid, input  exe_rsp_ready
    );
endinterface

`default_nettype wire

// File: rtl/xadac_mux_rr.sv
// ============================================================================
// Module   : xadac_mux_rr (+ xadac_mux_rr_arb)
// Brief    : XADAC 1-to-NO_MST demux with id scoreboard and round-robin
//            response merge. XADAC_MUX_SPILL_EN adds 2-entry response skids.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xadac_mux_rr_arb #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [N-1:0]      i_valid,
    input  wire logic [N-1:0][W-1:0] i_data,
    output logic      [N-1:0]      o_ready,
    output logic                   o_valid,
    output logic      [W-1:0]      o_data,
    input  wire logic              i_ready
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] w_grant;
    logic [IDX_W-1:0] w_cand;
    logic             w_any;
    logic             w_arb_ready;
    logic             w_hs;
    logic [W-1:0]     w_sel_data;

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        w_grant = ptr_q;
        w_any   = 1'b0;
        w_cand  = '0;
        if (lock_q) begin
            w_grant = lock_idx_q;
            w_any   = i_valid[lock_idx_q];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                w_cand = IDX_W'((int'(ptr_q) + k) % N);
                if (i_valid[w_cand]) begin
                    w_grant = w_cand;
                    w_any   = 1'b1;
                end
            end
        end
    end

    assign w_sel_data = i_data[w_grant];
    assign w_hs       = !rst && w_any && w_arb_ready;

    always_comb begin
        o_ready = '0;
        for (int i = 0; i < N; i++) begin
            o_ready[i] = w_hs && (w_grant == IDX_W'(i));
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (w_hs) begin
            ptr_d  = (w_grant == IDX_W'(N - 1)) ? '0 : w_grant + 1'b1;
            lock_d = 1'b0;
        end else if (w_any) begin
            lock_d     = 1'b1;
            lock_idx_d = w_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifdef XADAC_MUX_SPILL_EN
    logic [1:0][W-1:0] buf_q, buf_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              w_pop;

    assign w_arb_ready = (cnt_q != 2'd2);
    assign o_valid     = (cnt_q != 2'd0);
    assign o_data      = o_valid ? buf_q[rd_q] : '0;
    assign w_pop       = o_valid && i_ready;

    always_comb begin
        buf_d = buf_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (w_hs) begin
            buf_d[wr_q] = w_sel_data;
            wr_d        = ~wr_q;
        end
        if (w_pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + 2'(w_hs) - 2'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
`else
    assign w_arb_ready = i_ready;
    assign o_valid     = !rst && w_any;
    assign o_data      = (!rst && w_any) ? w_sel_data : '0;
`endif
endmodule

module xadac_mux_rr #(
    parameter int NO_MST  = 4,
    parameter int SB_LEN  = 8,
    parameter int ID_W    = 4,
    parameter int DATA_W  = 32,
    parameter int INSTR_W = 32,
    parameter logic [NO_MST-1:0][INSTR_W-1:0] MASK  = '0,
    parameter logic [NO_MST-1:0][INSTR_W-1:0] MATCH = '0,
    parameter int DEFAULT_MST = NO_MST - 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    xadac_mux_rr_if.slave    slv,
    xadac_mux_rr_if.master   mst,
    output logic [15:0]      sb_miss_cnt
);
    localparam int IDX_W    = (NO_MST > 1) ? $clog2(NO_MST) : 1;
    localparam int SB_IDX_W = (SB_LEN > 1) ? $clog2(SB_LEN) : 1;
    localparam logic [IDX_W-1:0] c_def_idx = IDX_W'(DEFAULT_MST);

    logic [SB_LEN-1:0]            sb_valid_q, sb_valid_d;
    logic [SB_LEN-1:0][IDX_W-1:0] sb_idx_q, sb_idx_d;
    logic [15:0]                  sb_miss_cnt_q, sb_miss_cnt_d;

    logic [INSTR_W-1:0]  w_dec_instr;
    logic [ID_W-1:0]     w_dec_id, w_exe_id;
    logic [SB_IDX_W-1:0] w_dec_sb, w_exe_sb;
    logic                w_dec_in, w_exe_in;
    logic [IDX_W-1:0]    w_dec_tgt, w_exe_tgt;
    logic                w_dec_hs, w_exe_hs;
    logic                w_exe_by, w_exe_hit;

    assign w_dec_instr = slv.dec_req[0][ID_W +: INSTR_W];
    assign w_dec_id    = slv.dec_req[0][ID_W-1:0];
    assign w_exe_id    = slv.exe_req[0][ID_W-1:0];
    assign w_dec_sb    = w_dec_id[SB_IDX_W-1:0];
    assign w_exe_sb    = w_exe_id[SB_IDX_W-1:0];
    assign w_dec_in    = int'(w_dec_id) < SB_LEN;
    assign w_exe_in    = int'(w_exe_id) < SB_LEN;

    // Lowest-index match wins; descending scan lets it overwrite the rest.
    always_comb begin
        w_dec_tgt = c_def_idx;
        for (int i = NO_MST - 1; i >= 0; i--) begin
            if ((w_dec_instr & MASK[i]) == MATCH[i]) begin
                w_dec_tgt = IDX_W'(i);
            end
        end
    end

    assign slv.dec_req_ready[0] = !rst && mst.dec_req_ready[w_dec_tgt];
    assign w_dec_hs = slv.dec_req_valid[0] && slv.dec_req_ready[0];

    // A decode of the same id in this cycle is newer than the stored entry.
    assign w_exe_by  = w_dec_hs && w_dec_in && (w_dec_id == w_exe_id);
    assign w_exe_hit = w_exe_by || (w_exe_in && sb_valid_q[w_exe_sb]);
    assign w_exe_tgt = w_exe_by  ? w_dec_tgt :
                       w_exe_hit ? sb_idx_q[w_exe_sb] : c_def_idx;

    assign slv.exe_req_ready[0] = !rst && mst.exe_req_ready[w_exe_tgt];
    assign w_exe_hs = slv.exe_req_valid[0] && slv.exe_req_ready[0];

    always_comb begin
        for (int i = 0; i < NO_MST; i++) begin
            mst.dec_req_valid[i] = !rst && slv.dec_req_valid[0] && (w_dec_tgt == IDX_W'(i));
            mst.dec_req[i]       = (!rst && (w_dec_tgt == IDX_W'(i))) ? slv.dec_req[0] : '0;
            mst.exe_req_valid[i] = !rst && slv.exe_req_valid[0] && (w_exe_tgt == IDX_W'(i));
            mst.exe_req[i]       = (!rst && (w_exe_tgt == IDX_W'(i))) ? slv.exe_req[0] : '0;
        end
    end

    // Invalidate first so a same-cycle decode write of that id takes priority.
    always_comb begin
        sb_valid_d    = sb_valid_q;
        sb_idx_d      = sb_idx_q;
        sb_miss_cnt_d = sb_miss_cnt_q;
        if (w_exe_hs && w_exe_hit) begin
            sb_valid_d[w_exe_sb] = 1'b0;
        end
        if (w_dec_hs && w_dec_in) begin
            sb_valid_d[w_dec_sb] = 1'b1;
            sb_idx_d[w_dec_sb]   = w_dec_tgt;
        end
        if (w_exe_hs && !w_exe_hit && (sb_miss_cnt_q != 16'hFFFF)) begin
            sb_miss_cnt_d = sb_miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid_q    <= '0;
            sb_idx_q      <= '0;
            sb_miss_cnt_q <= '0;
        end else begin
            sb_valid_q    <= sb_valid_d;
            sb_idx_q      <= sb_idx_d;
            sb_miss_cnt_q <= sb_miss_cnt_d;
        end
    end

    assign sb_miss_cnt = sb_miss_cnt_q;

    xadac_mux_rr_arb #(.N(NO_MST), .W(DATA_W)) u_dec_arb (
        .clk     (clk),
        .rst     (rst),
        .i_valid (mst.dec_rsp_valid),
        .i_data  (mst.dec_rsp),
        .o_ready (mst.dec_rsp_ready),
        .o_valid (slv.dec_rsp_valid[0]),
        .o_data  (slv.dec_rsp[0]),
        .i_ready (slv.dec_rsp_ready[0])
    );

    xadac_mux_rr_arb #(.N(NO_MST), .W(DATA_W)) u_exe_arb (
        .clk     (clk),
        .rst     (rst),
        .i_valid (mst.exe_rsp_valid),
        .i_data  (mst.exe_rsp),
        .o_ready (mst.exe_rsp_ready),
        .o_valid (slv.exe_rsp_valid[0]),
        .o_data  (slv.exe_rsp[0]),
        .i_ready (slv.exe_rsp_ready[0])
    );
endmodule

`default_nettype wire

// File: tb/tb_xadac_mux_rr.sv
// ============================================================================
// Module   : tb_xadac_mux_rr
// Brief    : Self-checking bench for xadac_mux_rr (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xadac_mux_rr;
    localparam int NO_MST  = 4;
    localparam int SB_LEN  = 8;
    localparam int ID_W    = 4;
    localparam int DATA_W  = 32;
    localparam int INSTR_W = 32;
    localparam int DEF     = 3;
    localparam logic [NO_MST-1:0][INSTR_W-1:0] c_MASK  =
        {32'hFFFF_FFFF, 32'h0000_007F, 32'h0000_007F, 32'h0000_007F};
    localparam logic [NO_MST-1:0][INSTR_W-1:0] c_MATCH =
        {32'hFFFF_FFFF, 32'h0000_005B, 32'h0000_000B, 32'h0000_002B};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sb_miss_cnt;

    xadac_mux_rr_if #(.N(1),      .ID_W(ID_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)) slv_if ();
    xadac_mux_rr_if #(.N(NO_MST), .ID_W(ID_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)) mst_if ();

    xadac_mux_rr #(
        .NO_MST(NO_MST), .SB_LEN(SB_LEN), .ID_W(ID_W), .DATA_W(DATA_W),
        .INSTR_W(INSTR_W), .MASK(c_MASK), .MATCH(c_MATCH), .DEFAULT_MST(DEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .slv         (slv_if),
        .mst         (mst_if),
        .sb_miss_cnt (sb_miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_sb[16];
    int m_miss = 0;
    int exp_q[$];
    logic [31:0] rsp_q[$];

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  id;
        int          tgt;
    } dec_vec_t;
    dec_vec_t dv[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_sb[i] = -1;
        m_miss = 0;
    endtask

    task automatic dec_txn(input logic [31:0] instr, input logic [3:0] id, input int tgt);
        slv_if.dec_req[0]       = {instr, id};
        slv_if.dec_req_valid[0] = 1'b1;
        #4;
        chk("dec_route", 64'(mst_if.dec_req_valid), 64'(1) << tgt);
        chk("dec_payload", 64'(mst_if.dec_req[tgt]), 64'({instr, id}));
        chk("dec_ready", 64'(slv_if.dec_req_ready[0]), 64'd1);
        tick();
        if (int'(id) < SB_LEN) m_sb[id] = tgt;
        slv_if.dec_req_valid[0] = 1'b0;
    endtask

    task automatic exe_txn(input logic [3:0] id, input logic [31:0] data);
        int  t;
        bit  seen;
        if (int'(id) < SB_LEN && m_sb[id] >= 0) begin
            t = m_sb[id];
            m_sb[id] = -1;
        end else begin
            t = DEF;
            m_miss++;
        end
        exp_q.push_back(t);
        slv_if.exe_req[0]       = {data, id};
        slv_if.exe_req_valid[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            #4;
            if (mst_if.exe_req_valid != '0) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL exe_route_timeout: got no master valid, required one-hot %0d", t);
            void'(exp_q.pop_front());
        end else begin
            t = exp_q.pop_front();
            chk("exe_route", 64'(mst_if.exe_req_valid), 64'(1) << t);
            chk("exe_payload", 64'(mst_if.exe_req[t]), 64'({data, id}));
            chk("exe_ready", 64'(slv_if.exe_req_ready[0]), 64'd1);
            tick();
        end
        slv_if.exe_req_valid[0] = 1'b0;
        chk("miss_cnt", 64'(sb_miss_cnt), 64'(m_miss));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dv[0] = '{32'h0000_000B, 4'd3,  1};
        dv[1] = '{32'h0000_0033, 4'd5,  3};
        dv[2] = '{32'h0000_002B, 4'd0,  0};
        dv[3] = '{32'h1234_565B, 4'd1,  2};
        dv[4] = '{32'h0000_00FF, 4'd4,  3};
        dv[5] = '{32'h0000_008B, 4'd7,  1};
        dv[6] = '{32'h0000_000B, 4'd12, 1};
        model_reset();

        slv_if.dec_req = '0; slv_if.dec_req_valid = '0; slv_if.dec_rsp_ready = '0;
        slv_if.exe_req = '0; slv_if.exe_req_valid = '0; slv_if.exe_rsp_ready = '0;
        mst_if.dec_req_ready = '1; mst_if.exe_req_ready = '1;
        mst_if.dec_rsp = '0; mst_if.dec_rsp_valid = '0;
        mst_if.exe_rsp = '0; mst_if.exe_rsp_valid = '0;

        // Reset state with a request already presented.
        slv_if.dec_req_valid[0] = 1'b1;
        #3;
        chk("rst_dec_valid", 64'(mst_if.dec_req_valid), 64'd0);
        chk("rst_dec_ready", 64'(slv_if.dec_req_ready[0]), 64'd0);
        chk("rst_rsp_valid", 64'(slv_if.dec_rsp_valid[0]), 64'd0);
        chk("rst_miss", 64'(sb_miss_cnt), 64'd0);
        slv_if.dec_req_valid[0] = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) dec_txn(dv[i].instr, dv[i].id, dv[i].tgt);

        // Target not ready: no handshake, scoreboard untouched.
        mst_if.exe_req_ready = 4'b1101;
        slv_if.exe_req[0] = {32'hAAAA_0000, 4'd3};
        slv_if.exe_req_valid[0] = 1'b1;
        #4;
        chk("exe_stall_route", 64'(mst_if.exe_req_valid), 64'b0010);
        chk("exe_stall_ready", 64'(slv_if.exe_req_ready[0]), 64'd0);
        tick();
        slv_if.exe_req_valid[0] = 1'b0;
        mst_if.exe_req_ready = '1;
        chk("exe_stall_miss", 64'(sb_miss_cnt), 64'd0);

        exe_txn(4'd3,  32'h0000_1003);
        exe_txn(4'd5,  32'h0000_1005);
        exe_txn(4'd0,  32'h0000_1000);
        exe_txn(4'd1,  32'h0000_1001);
        exe_txn(4'd4,  32'h0000_1004);
        exe_txn(4'd7,  32'h0000_1007);
        exe_txn(4'd6,  32'h0000_1006);
        exe_txn(4'd3,  32'h0000_2003);
        exe_txn(4'd12, 32'h0000_100C);

        // Exe response round robin: masters 0,2,3 valid.
        for (int i = 0; i < NO_MST; i++) mst_if.exe_rsp[i] = 32'hE000_0000 + 32'(i);
        mst_if.exe_rsp_valid = 4'b1101;
        slv_if.exe_rsp_ready[0] = 1'b1;
        rsp_q.push_back(32'hE000_0000);
        rsp_q.push_back(32'hE000_0002);
        rsp_q.push_back(32'hE000_0003);
        rsp_q.push_back(32'hE000_0000);
        for (int c = 0; c < 4; c++) begin
            logic [31:0] e;
            e = rsp_q.pop_front();
            #4;
            chk("exe_rr_valid", 64'(slv_if.exe_rsp_valid[0]), 64'd1);
            chk("exe_rr_data", 64'(slv_if.exe_rsp[0]), 64'(e));
            chk("exe_rr_ready", 64'(mst_if.exe_rsp_ready), 64'(1) << e[1:0]);
            tick();
        end
        mst_if.exe_rsp_valid = '0;
        slv_if.exe_rsp_ready[0] = 1'b0;

        // Dec response grant lock with back-pressure.
        for (int i = 0; i < NO_MST; i++) mst_if.dec_rsp[i] = 32'hD000_0000 + 32'(i);
        mst_if.dec_rsp_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #4;
            chk("dec_lock_valid", 64'(slv_if.dec_rsp_valid[0]), 64'd1);
            chk("dec_lock_data", 64'(slv_if.dec_rsp[0]), 64'hD000_0002);
            chk("dec_lock_ready", 64'(mst_if.dec_rsp_ready), 64'd0);
            tick();
            mst_if.dec_rsp_valid = 4'b0101;
        end
        slv_if.dec_rsp_ready[0] = 1'b1;
        #4;
        chk("dec_lock_rel_data", 64'(slv_if.dec_rsp[0]), 64'hD000_0002);
        chk("dec_lock_rel_ready", 64'(mst_if.dec_rsp_ready), 64'b0100);
        tick();
        mst_if.dec_rsp_valid = 4'b0001;
        #4;
        chk("dec_next_data", 64'(slv_if.dec_rsp[0]), 64'hD000_0000);
        chk("dec_next_ready", 64'(mst_if.dec_rsp_ready), 64'b0001);
        tick();
        mst_if.dec_rsp_valid = 4'b1001;
        #4;
        chk("dec_ptr_data", 64'(slv_if.dec_rsp[0]), 64'hD000_0003);
        tick();
        mst_if.dec_rsp_valid = '0;
        slv_if.dec_rsp_ready[0] = 1'b0;

        // Same-cycle decode rewrites a stale entry seen by execute.
        dec_txn(32'h0000_002B, 4'd2, 0);
        slv_if.dec_req[0] = {32'h0000_000B, 4'd2};
        slv_if.dec_req_valid[0] = 1'b1;
        slv_if.exe_req[0] = {32'h0000_3002, 4'd2};
        slv_if.exe_req_valid[0] = 1'b1;
        #4;
        chk("bypass_dec_route", 64'(mst_if.dec_req_valid), 64'b0010);
        chk("bypass_exe_route", 64'(mst_if.exe_req_valid), 64'b0010);
        tick();
        m_sb[2] = 1;
        slv_if.dec_req_valid[0] = 1'b0;
        slv_if.exe_req_valid[0] = 1'b0;
        chk("bypass_miss", 64'(sb_miss_cnt), 64'(m_miss));
        exe_txn(4'd2, 32'h0000_3012);

        // Reset mid-burst.
        dec_txn(32'h0000_000B, 4'd3, 1);
        slv_if.dec_req[0] = {32'h0000_000B, 4'd4};
        slv_if.dec_req_valid[0] = 1'b1;
        slv_if.exe_req[0] = {32'h0000_4005, 4'd5};
        slv_if.exe_req_valid[0] = 1'b1;
        mst_if.dec_rsp_valid = '1;
        mst_if.exe_rsp_valid = '1;
        slv_if.dec_rsp_ready[0] = 1'b1;
        slv_if.exe_rsp_ready[0] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_dec_valid", 64'(mst_if.dec_req_valid), 64'd0);
        chk("mrst_exe_valid", 64'(mst_if.exe_req_valid), 64'd0);
        chk("mrst_req_ready", 64'({slv_if.dec_req_ready[0], slv_if.exe_req_ready[0]}), 64'd0);
        chk("mrst_rsp_valid", 64'({slv_if.dec_rsp_valid[0], slv_if.exe_rsp_valid[0]}), 64'd0);
        chk("mrst_rsp_ready", 64'({mst_if.dec_rsp_ready, mst_if.exe_rsp_ready}), 64'd0);
        chk("mrst_payload", 64'(mst_if.dec_req[1]), 64'd0);
        slv_if.dec_req_valid[0] = 1'b0;
        slv_if.exe_req_valid[0] = 1'b0;
        mst_if.dec_rsp_valid = '0;
        mst_if.exe_rsp_valid = '0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        tick();
        chk("post_rst_miss", 64'(sb_miss_cnt), 64'd0);
        exe_txn(4'd3, 32'h0000_5003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
